// File: rtl/hdmi_pattern_sequencer.sv
// hdmi_pattern_sequencer: frame-level controller for the HDMI pattern driver.
// Detects the rising edge of vertical sync, counts frames, drives the
// animation time_count and the pattern select, and applies host configuration
// (auto-cycle / hold / blank) only at frame boundaries so no frame is torn.
module hdmi_pattern_sequencer #(
   parameter int FRAMES_PER_PATTERN = 60,
   parameter int NUM_PATTERNS       = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        vs,
   input  logic        cfg_valid,
   input  logic [1:0]  cfg_mode,
   input  logic [1:0]  cfg_pattern,
   output logic        cfg_ready,
   output logic [1:0]  pattern_sel,
   output logic [15:0] time_count,
   output logic        blank,
   output logic        frame_start,
   output logic [7:0]  frame_cnt
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      AUTO  = 2'd1,
      HOLD  = 2'd2,
      BLANK = 2'd3
   } state_t;

   localparam logic [7:0] LAST_FRAME = 8'(FRAMES_PER_PATTERN - 1);
   localparam logic [2:0] NUM_PAT    = 3'(NUM_PATTERNS);
   localparam logic [2:0] LAST_PAT   = 3'(NUM_PATTERNS - 1);

   state_t      state, state_nxt;
   logic        vs_d;
   logic        frame_edge;
   logic        pending, pending_nxt;
   logic [1:0]  pend_mode, pend_mode_nxt;
   logic [1:0]  pend_pat, pend_pat_nxt;
   logic [1:0]  pattern_sel_nxt;
   logic [15:0] time_count_nxt;
   logic        blank_nxt;
   logic        frame_start_nxt;
   logic [7:0]  frame_cnt_nxt;
   logic        cfg_ready_nxt;

   // Mode 3 is not a distinct mode; it behaves exactly like BLANK.
   function automatic state_t decode_mode(input logic [1:0] mode);
      case (mode)
         2'd0:    return AUTO;
         2'd1:    return HOLD;
         default: return BLANK;
      endcase
   endfunction

   // An out-of-range start pattern in AUTO restarts the cycle at pattern 0.
   function automatic logic [1:0] clamp_pattern(input logic [1:0] pat);
      if ({1'b0, pat} >= NUM_PAT) return 2'd0;
      return pat;
   endfunction

   // Advance to the next pattern of the auto cycle, wrapping at NUM_PATTERNS.
   function automatic logic [1:0] next_pattern(input logic [1:0] pat);
      if ({1'b0, pat} >= LAST_PAT) return 2'd0;
      return pat + 2'd1;
   endfunction

   assign frame_edge = vs & ~vs_d;

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   // Next-state, handshake and frame-level output computation.
   always_comb begin
      state_nxt       = state;
      pending_nxt     = pending;
      pend_mode_nxt   = pend_mode;
      pend_pat_nxt    = pend_pat;
      pattern_sel_nxt = pattern_sel;
      time_count_nxt  = time_count;
      frame_cnt_nxt   = frame_cnt;
      frame_start_nxt = 1'b0;

      // cfg_ready mirrors ~pending, so an accept can never coincide with an apply.
      if (cfg_valid && cfg_ready) begin
         pending_nxt   = 1'b1;
         pend_mode_nxt = cfg_mode;
         pend_pat_nxt  = cfg_pattern;
      end

      if (frame_edge) begin
         frame_start_nxt = 1'b1;
         time_count_nxt  = time_count + 16'd1;
         if (pending) begin
            pending_nxt   = 1'b0;
            state_nxt     = decode_mode(pend_mode);
            frame_cnt_nxt = 8'd0;
            case (decode_mode(pend_mode))
               AUTO:    pattern_sel_nxt = clamp_pattern(pend_pat);
               HOLD:    pattern_sel_nxt = pend_pat;
               default: pattern_sel_nxt = pattern_sel;
            endcase
         end else begin
            case (state)
               IDLE: begin
                  state_nxt       = AUTO;
                  pattern_sel_nxt = 2'd0;
                  frame_cnt_nxt   = 8'd0;
               end
               AUTO: begin
                  if (frame_cnt == LAST_FRAME) begin
                     frame_cnt_nxt   = 8'd0;
                     pattern_sel_nxt = next_pattern(pattern_sel);
                  end else begin
                     frame_cnt_nxt = frame_cnt + 8'd1;
                  end
               end
               default: frame_cnt_nxt = 8'd0;
            endcase
         end
      end

      blank_nxt     = (state_nxt == IDLE) || (state_nxt == BLANK);
      cfg_ready_nxt = ~pending_nxt;
   end

   // Registered outputs, sync edge detector and pending configuration.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vs_d        <= 1'b0;
         pending     <= 1'b0;
         pend_mode   <= 2'd0;
         pend_pat    <= 2'd0;
         pattern_sel <= 2'd0;
         time_count  <= 16'd0;
         blank       <= 1'b1;
         frame_start <= 1'b0;
         frame_cnt   <= 8'd0;
         cfg_ready   <= 1'b1;
      end else begin
         vs_d        <= vs;
         pending     <= pending_nxt;
         pend_mode   <= pend_mode_nxt;
         pend_pat    <= pend_pat_nxt;
         pattern_sel <= pattern_sel_nxt;
         time_count  <= time_count_nxt;
         blank       <= blank_nxt;
         frame_start <= frame_start_nxt;
         frame_cnt   <= frame_cnt_nxt;
         cfg_ready   <= cfg_ready_nxt;
      end
   end

endmodule

// File: tb/tb_hdmi_pattern_sequencer.sv
// Testbench for hdmi_pattern_sequencer: scenario tasks with inline checks
// against a frame-level reference model (pattern derived from frames elapsed).
module tb_hdmi_pattern_sequencer;

   localparam int FPP = 3;
   localparam int NP  = 4;
   localparam int M_IDLE = 0, M_AUTO = 1, M_HOLD = 2, M_BLANK = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        vs = 1'b0;
   logic        cfg_valid = 1'b0;
   logic [1:0]  cfg_mode = 2'd0;
   logic [1:0]  cfg_pattern = 2'd0;
   logic        cfg_ready;
   logic [1:0]  pattern_sel;
   logic [15:0] time_count;
   logic        blank;
   logic        frame_start;
   logic [7:0]  frame_cnt;

   int n_cmp = 0;
   int n_err = 0;
   int fs_count = 0;

   // Reference model state
   int          m_state;
   int          m_start;
   int          m_frames;
   logic [1:0]  m_pat;
   logic [7:0]  m_cnt;
   logic [15:0] m_tc;
   logic        m_blank;
   bit          m_pending;
   logic [1:0]  m_pmode;
   logic [1:0]  m_ppat;

   always #5 clk = ~clk;

   hdmi_pattern_sequencer #(
      .FRAMES_PER_PATTERN(FPP),
      .NUM_PATTERNS(NP)
   ) dut (
      .clk(clk),
      .rst(rst),
      .vs(vs),
      .cfg_valid(cfg_valid),
      .cfg_mode(cfg_mode),
      .cfg_pattern(cfg_pattern),
      .cfg_ready(cfg_ready),
      .pattern_sel(pattern_sel),
      .time_count(time_count),
      .blank(blank),
      .frame_start(frame_start),
      .frame_cnt(frame_cnt)
   );

   always @(negedge clk) if (frame_start === 1'b1) fs_count++;

   // ---------------- reference model ----------------
   function automatic void model_derive();
      if (m_state == M_AUTO) begin
         m_pat = 2'((m_start + m_frames / FPP) % NP);
         m_cnt = 8'(m_frames % FPP);
      end else begin
         m_cnt = 8'd0;
      end
      m_blank = (m_state == M_IDLE) || (m_state == M_BLANK);
   endfunction

   function automatic void model_reset();
      m_state = M_IDLE; m_start = 0; m_frames = 0; m_pat = 2'd0; m_cnt = 8'd0;
      m_tc = 16'd0; m_blank = 1'b1; m_pending = 1'b0; m_pmode = 2'd0; m_ppat = 2'd0;
   endfunction

   function automatic void model_edge();
      m_tc = m_tc + 16'd1;
      if (m_pending) begin
         m_pending = 1'b0;
         if (m_pmode == 2'd0) begin
            m_state = M_AUTO; m_frames = 0;
            m_start = (int'(m_ppat) < NP) ? int'(m_ppat) : 0;
         end else if (m_pmode == 2'd1) begin
            m_state = M_HOLD; m_pat = m_ppat;
         end else begin
            m_state = M_BLANK;
         end
      end else if (m_state == M_IDLE) begin
         m_state = M_AUTO; m_start = 0; m_frames = 0;
      end else if (m_state == M_AUTO) begin
         m_frames++;
      end
      model_derive();
   endfunction

   // ---------------- stimulus helpers (no checking) ----------------
   task automatic send_cfg(input logic [1:0] md, input logic [1:0] pt);
      bit ready_old;
      @(negedge clk);
      cfg_valid = 1'b1; cfg_mode = md; cfg_pattern = pt;
      @(negedge clk);
      cfg_valid = 1'b0;
      ready_old = !m_pending;
      if (ready_old) begin m_pending = 1'b1; m_pmode = md; m_ppat = pt; end
   endtask

   task automatic frame_edge(input bit c_en, input logic [1:0] md, input logic [1:0] pt);
      bit ready_old;
      @(negedge clk);
      vs = 1'b1; cfg_valid = c_en; cfg_mode = md; cfg_pattern = pt;
      @(negedge clk);
      cfg_valid = 1'b0;
      ready_old = !m_pending;
      model_edge();
      if (c_en && ready_old) begin m_pending = 1'b1; m_pmode = md; m_ppat = pt; end
   endtask

   task automatic frame_tail(input int hi, input int lo);
      repeat (hi - 1) @(negedge clk);
      vs = 1'b0;
      repeat (lo) @(negedge clk);
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst = 1'b0; vs = 1'b0;
      model_reset();
      #23;
      if (pattern_sel !== 2'd0) begin n_err++; $display("FAIL reset_pattern_sel got %0d want 0", pattern_sel); end
      n_cmp++;
      if (time_count !== 16'd0) begin n_err++; $display("FAIL reset_time_count got %0d want 0", time_count); end
      n_cmp++;
      if (blank !== 1'b1) begin n_err++; $display("FAIL reset_blank got %b want 1", blank); end
      n_cmp++;
      if (frame_start !== 1'b0 || frame_cnt !== 8'd0) begin
         n_err++; $display("FAIL reset_frame got fs=%b cnt=%0d want 0/0", frame_start, frame_cnt);
      end
      n_cmp++;
      if (cfg_ready !== 1'b1) begin n_err++; $display("FAIL reset_cfg_ready got %b want 1", cfg_ready); end
      n_cmp++;
      @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      if (blank !== 1'b1 || time_count !== 16'd0) begin
         n_err++; $display("FAIL idle_no_edge got blank=%b tc=%0d want 1/0", blank, time_count);
      end
      n_cmp++;
   endtask

   task automatic test_auto_cycle();
      logic [1:0] exp_seq [13];
      int fs0;
      exp_seq = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd3, 2'd3, 2'd3, 2'd0};
      fs0 = fs_count;
      for (int i = 0; i < 13; i++) begin
         int hi;
         hi = int'($urandom_range(1, 20));
         frame_edge(1'b0, 2'd0, 2'd0);
         if (pattern_sel !== exp_seq[i]) begin
            n_err++; $display("FAIL auto_seq[%0d] got %0d want %0d", i, pattern_sel, exp_seq[i]);
         end
         n_cmp++;
         if (frame_cnt !== m_cnt || blank !== 1'b0) begin
            n_err++; $display("FAIL auto_cnt_blank[%0d] got cnt=%0d blank=%b want %0d/0", i, frame_cnt, blank, m_cnt);
         end
         n_cmp++;
         frame_tail(hi, 99 - hi);
      end
      if (fs_count - fs0 !== 13) begin n_err++; $display("FAIL auto_frame_starts got %0d want 13", fs_count - fs0); end
      n_cmp++;
      if (time_count !== 16'd13) begin n_err++; $display("FAIL auto_time_count got %0d want 13", time_count); end
      n_cmp++;
   endtask

   task automatic test_hold_cfg();
      repeat (int'($urandom_range(5, 30))) @(negedge clk);
      send_cfg(2'd1, 2'd2);
      if (cfg_ready !== 1'b0) begin n_err++; $display("FAIL hold_ready_drop got %b want 0", cfg_ready); end
      n_cmp++;
      send_cfg(2'd0, 2'd0);
      frame_edge(1'b0, 2'd0, 2'd0);
      if (pattern_sel !== 2'd2 || frame_cnt !== 8'd0) begin
         n_err++; $display("FAIL hold_apply got pat=%0d cnt=%0d want 2/0", pattern_sel, frame_cnt);
      end
      n_cmp++;
      if (cfg_ready !== 1'b1) begin n_err++; $display("FAIL hold_ready_back got %b want 1", cfg_ready); end
      n_cmp++;
      frame_tail(5, 90);
      for (int i = 0; i < 5; i++) begin
         frame_edge(1'b0, 2'd0, 2'd0);
         if (pattern_sel !== 2'd2 || frame_cnt !== 8'd0 || blank !== 1'b0) begin
            n_err++; $display("FAIL hold_frame[%0d] got pat=%0d cnt=%0d blank=%b want 2/0/0", i, pattern_sel, frame_cnt, blank);
         end
         n_cmp++;
         frame_tail(5, 90);
      end
   endtask

   task automatic test_cfg_same_edge();
      frame_edge(1'b1, 2'd0, 2'd1);
      if (pattern_sel !== 2'd2 || cfg_ready !== 1'b0) begin
         n_err++; $display("FAIL same_edge_noapply got pat=%0d ready=%b want 2/0", pattern_sel, cfg_ready);
      end
      n_cmp++;
      frame_tail(5, 90);
      frame_edge(1'b0, 2'd0, 2'd0);
      if (pattern_sel !== 2'd1 || frame_cnt !== 8'd0 || cfg_ready !== 1'b1) begin
         n_err++; $display("FAIL same_edge_apply got pat=%0d cnt=%0d ready=%b want 1/0/1", pattern_sel, frame_cnt, cfg_ready);
      end
      n_cmp++;
      frame_tail(5, 90);
   endtask

   task automatic test_blank();
      logic [1:0]  pat0;
      logic [15:0] tc0;
      pat0 = m_pat;
      send_cfg(2'd2, pat0);
      frame_edge(1'b0, 2'd0, 2'd0);
      tc0 = m_tc;
      if (blank !== 1'b1 || pattern_sel !== pat0 || frame_cnt !== 8'd0) begin
         n_err++; $display("FAIL blank_apply got blank=%b pat=%0d cnt=%0d want 1/%0d/0", blank, pattern_sel, frame_cnt, pat0);
      end
      n_cmp++;
      frame_tail(3, 96);
      for (int i = 1; i <= 4; i++) begin
         frame_edge(1'b0, 2'd0, 2'd0);
         if (blank !== 1'b1 || pattern_sel !== pat0 || time_count !== tc0 + 16'(i)) begin
            n_err++; $display("FAIL blank_frame[%0d] got blank=%b pat=%0d tc=%0d want 1/%0d/%0d", i, blank, pattern_sel, time_count, pat0, tc0 + 16'(i));
         end
         n_cmp++;
         frame_tail(3, 96);
      end
      send_cfg(2'd0, 2'd3);
      frame_edge(1'b0, 2'd0, 2'd0);
      if (pattern_sel !== 2'd3 || blank !== 1'b0 || frame_cnt !== 8'd0) begin
         n_err++; $display("FAIL blank_to_auto got pat=%0d blank=%b cnt=%0d want 3/0/0", pattern_sel, blank, frame_cnt);
      end
      n_cmp++;
      frame_tail(3, 96);
   endtask

   task automatic test_wrap();
      @(negedge clk);
      force dut.time_count = 16'hFFFE;
      @(negedge clk);
      @(negedge clk);
      release dut.time_count;
      m_tc = 16'hFFFE;
      @(negedge clk);
      frame_edge(1'b0, 2'd0, 2'd0);
      if (time_count !== 16'hFFFF) begin n_err++; $display("FAIL wrap_pre got %0h want ffff", time_count); end
      n_cmp++;
      frame_tail(2, 10);
      frame_edge(1'b0, 2'd0, 2'd0);
      if (time_count !== 16'h0000 || pattern_sel !== m_pat) begin
         n_err++; $display("FAIL wrap_zero got tc=%0h pat=%0d want 0/%0d", time_count, pattern_sel, m_pat);
      end
      n_cmp++;
      frame_tail(2, 10);
   endtask

   task automatic test_reset_pending();
      int fs0;
      send_cfg(2'd1, 2'd1);
      if (cfg_ready !== 1'b0) begin n_err++; $display("FAIL rstpend_ready_drop got %b want 0", cfg_ready); end
      n_cmp++;
      @(negedge clk);
      #2;
      rst = 1'b0;
      vs = 1'b1;
      model_reset();
      #1;
      if (cfg_ready !== 1'b1 || blank !== 1'b1 || pattern_sel !== 2'd0 || time_count !== 16'd0 ||
          frame_cnt !== 8'd0 || frame_start !== 1'b0) begin
         n_err++; $display("FAIL rstpend_async got ready=%b blank=%b pat=%0d tc=%0d cnt=%0d fs=%b want 1/1/0/0/0/0",
                           cfg_ready, blank, pattern_sel, time_count, frame_cnt, frame_start);
      end
      n_cmp++;
      fs0 = fs_count;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      model_edge();
      if (frame_start !== 1'b1 || pattern_sel !== 2'd0 || blank !== 1'b0 || time_count !== 16'd1) begin
         n_err++; $display("FAIL rstpend_first_edge got fs=%b pat=%0d blank=%b tc=%0d want 1/0/0/1",
                           frame_start, pattern_sel, blank, time_count);
      end
      n_cmp++;
      repeat (10) @(negedge clk);
      if (fs_count - fs0 !== 1) begin n_err++; $display("FAIL rstpend_one_pulse got %0d want 1", fs_count - fs0); end
      n_cmp++;
      vs = 1'b0;
      repeat (5) @(negedge clk);
   endtask

   task automatic test_random();
      for (int i = 0; i < 60; i++) begin
         int         r;
         logic [1:0] md;
         logic [1:0] pt;
         r  = int'($urandom_range(0, 2));
         md = 2'($urandom_range(0, 3));
         pt = 2'($urandom_range(0, 3));
         if (md >= 2'd2) begin
            pt = m_pat;
            if (r == 2) r = 1;
         end
         if (r == 1) begin
            repeat (int'($urandom_range(0, 4))) @(negedge clk);
            send_cfg(md, pt);
         end
         frame_edge(r == 2, md, pt);
         if (frame_start !== 1'b1 || pattern_sel !== m_pat || frame_cnt !== m_cnt) begin
            n_err++; $display("FAIL rand_frame[%0d] got fs=%b pat=%0d cnt=%0d want 1/%0d/%0d", i, frame_start, pattern_sel, frame_cnt, m_pat, m_cnt);
         end
         n_cmp++;
         if (blank !== m_blank || time_count !== m_tc || cfg_ready !== !m_pending) begin
            n_err++; $display("FAIL rand_ctrl[%0d] got blank=%b tc=%0d ready=%b want %b/%0d/%b", i, blank, time_count, cfg_ready, m_blank, m_tc, !m_pending);
         end
         n_cmp++;
         @(negedge clk);
         if (frame_start !== 1'b0) begin n_err++; $display("FAIL rand_pulse_width[%0d] got %b want 0", i, frame_start); end
         n_cmp++;
         frame_tail(int'($urandom_range(1, 5)), int'($urandom_range(1, 20)));
      end
   endtask

   initial begin
      test_reset();
      test_auto_cycle();
      test_hold_cfg();
      test_cfg_same_edge();
      test_blank();
      test_wrap();
      test_reset_pending();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/hdmi_pattern_sequencer.md
# hdmi_pattern_sequencer

Frame-level controller for the HDMI timing/pattern driver. It watches the driver's vertical sync, counts frames, and generates the `time_count` animation input and a pattern select for the driver's RGB generator. A host-side valid/ready configuration port selects auto-cycle, fixed-pattern or blank mode. Every configuration change is applied only at a frame boundary, so no frame is ever torn.

## Interface
Parameters:
- `FRAMES_PER_PATTERN`, default 60: frames shown per pattern in auto mode; legal range 1..255.
- `NUM_PATTERNS`, default 4: number of patterns in the auto cycle; legal range 1..4.

Ports:
- `clk`  in  1: pixel clock, the same clock as the driver.
- `rst`  in  1: asynchronous, active-low reset.
- `vs`  in  1: vertical sync from the driver, active-high.
- `cfg_valid`  in  1: configuration request.
- `cfg_mode`  in  2: 0 = AUTO, 1 = HOLD, 2 = BLANK, 3 = treated as BLANK.
- `cfg_pattern`  in  2: start pattern (AUTO) or fixed pattern (HOLD).
- `cfg_ready`  out  1: configuration can be accepted.
- `pattern_sel`  out  2: pattern index to the driver.
- `time_count`  out  16: frame counter to the driver's `time_count` input.
- `blank`  out  1: driver forces RGB to 0 when high.
- `frame_start`  out  1: one-cycle pulse per frame boundary.
- `frame_cnt`  out  8: frames shown of the current pattern in AUTO.

## Operation
- **Frame edge detection**
  - `vs_d` registers `vs` every cycle.
  - `edge = vs & ~vs_d`, combinational.
  - All frame-level updates occur on the clock where `edge` = 1.
- **States:** IDLE, AUTO, HOLD, BLANK.
- **Reset values:** state = IDLE, `pattern_sel` = 0, `time_count` = 0, `blank` = 1, `frame_start` = 0, `frame_cnt` = 0, `cfg_ready` = 1, `pending` = 0, `vs_d` = 0.
- **Configuration handshake**
  - Accept on `cfg_valid & cfg_ready`: latch mode and pattern into the pending registers, set `pending` = 1, and drop `cfg_ready` next cycle.
  - `cfg_ready` = ~`pending` (registered).
  - While `pending` = 1, `cfg_valid` is ignored.
- **Applying a configuration**
  - A pending configuration is applied on an `edge` clock where `pending` was already 1 at that clock.
  - On apply: state = cfg mode, `frame_cnt` = 0, `pattern_sel` = cfg_pattern, and `pending` clears, so `cfg_ready` = 1 on the following cycle.
  - If cfg_pattern ≥ `NUM_PATTERNS` in AUTO, `pattern_sel` = 0. HOLD uses cfg_pattern unclamped.
- **IDLE:** `blank` = 1. On the first `edge`, a pending config applies if present; otherwise go to AUTO with `pattern_sel` = 0.
- **AUTO:** `blank` = 0. On each `edge` without an apply:
  - If `frame_cnt` == `FRAMES_PER_PATTERN`-1: `frame_cnt` = 0 and `pattern_sel` = (`pattern_sel`+1) mod `NUM_PATTERNS`.
  - Otherwise `frame_cnt` += 1.
- **HOLD:** `blank` = 0; `pattern_sel` fixed; `frame_cnt` held at 0.
- **BLANK:** `blank` = 1; `pattern_sel` retains its last value; `frame_cnt` held at 0.
- **time_count:** +1 on every `edge` in every state, including IDLE and BLANK. Wraps 0xFFFF → 0x0000 with no flag.

## Timing
- All outputs are registered.
- `frame_start`, `time_count`, `pattern_sel`, `frame_cnt`, `blank` and state all update together, visible the cycle after the first clock that samples `vs` = 1. Latency from `vs` rising to outputs is 1 clock.
- `vs` held high for many cycles produces exactly one `frame_start`.
- If `vs` rises in the same cycle a config is accepted, the config is not applied at that edge; it applies at the next edge.
- **Reset asserted mid-frame:** all outputs go to their reset values immediately (asynchronous). After release, the next `edge` behaves as the first edge from IDLE.
  - If `vs` is already high at release, `vs_d` = 0 yields an edge on the first clock after release.
- `cfg_ready` deasserts exactly 1 cycle after acceptance and reasserts 1 cycle after apply. Worst-case hold-off is one frame.

## Test plan
Use `FRAMES_PER_PATTERN` = 3, `NUM_PATTERNS` = 4, and a `vs` pulse every 100 clocks for the scenarios below.
- **Reset then 13 frames, no config:**
  - Edge 1: IDLE→AUTO.
  - `pattern_sel` sequence 0,0,0,1,1,1,2,2,2,3,3,3,0.
  - Exactly 13 `frame_start` pulses.
  - `time_count` = 13, `blank` = 0 from edge 1.
- **Config HOLD/2 mid-frame:**
  - `cfg_ready` drops next cycle.
  - At the next edge `pattern_sel` = 2, `frame_cnt` = 0.
  - `cfg_ready` = 1 one cycle later.
  - `pattern_sel` stays 2 for 5 frames.
- **Config accepted in the same cycle `vs` rises:** no change at that edge; applied at the following edge.
- **BLANK mode for 4 frames:** `blank` = 1, `pattern_sel` unchanged, `time_count` still +4. Then AUTO/cfg_pattern 3: `pattern_sel` = 3 and `blank` = 0 at the apply edge.
- **Wrap-around:** preload via 65535 edges (or force); the next edge gives `time_count` = 0.
- **Reset pulse mid-frame while `pending` = 1:**
  - Outputs return to reset values and the pending config is discarded.
  - `vs` held high across release gives exactly one `frame_start`, one clock after release.
